// File: rtl/char_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// char_buffer_ctrl
//
// Command front end for a 16 x 64 character buffer. Accepts single-cell
// writes, region clears (screen, end-of-line, end-of-screen) and, when the
// CHAR_BUFFER_CTRL_SCROLL_EN macro is defined, a one-row scroll-up. Video
// reads always own the buffer read port; scroll reads wait for free cycles.
//
// Build option:
//   CHAR_BUFFER_CTRL_SCROLL_EN  defined   -> op 4 (SCROLL_UP) implemented
//                               undefined -> op 4 is a no-op
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                0 WRITE, 1 CLEAR_SCREEN, 2 CLEAR_EOL, 3 CLEAR_EOS,
//                         4 SCROLL_UP, 5-7 no-op
//   cmd_addr              cell address {row[3:0], col[5:0]}
//   cmd_data              character for WRITE
//   vid_rd_en, vid_raddr  video read request (highest priority)
//   buf_we/waddr/din      buffer write port
//   buf_read_en/raddr     buffer read port request
//   buf_dout              buffer read data, valid one cycle after the request
//   busy                  high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module char_buffer_ctrl #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       vid_rd_en,
    input  logic [9:0] vid_raddr,
    output logic       buf_we,
    output logic [9:0] buf_waddr,
    output logic [7:0] buf_din,
    output logic       buf_read_en,
    output logic [9:0] buf_raddr,
    input  logic [7:0] buf_dout,
    output logic       busy
);

    localparam logic [2:0] OpWrite     = 3'd0;
    localparam logic [2:0] OpClrScreen = 3'd1;
    localparam logic [2:0] OpClrEol    = 3'd2;
    localparam logic [2:0] OpClrEos    = 3'd3;

`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
    localparam logic [2:0] OpScrollUp  = 3'd4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFill    = 2'd1,
        StScrCopy = 2'd2,
        StScrFill = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1
    } state_e;
`endif

    state_e     state_q, state_d;

    // Registered write port: WRITE and all fill writes go through these.
    logic       we_q, we_d;
    logic [9:0] waddr_q, waddr_d;
    logic [7:0] din_q, din_d;
    // Last address of the active fill run (inclusive).
    logic [9:0] fill_end_q, fill_end_d;

    logic       cmd_fire;

    assign cmd_fire = cmd_valid && (state_q == StIdle);

`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
    // Next source cell to read; bit 10 set means every source has been read.
    logic [10:0] src_q, src_d;
    // A scroll read was issued last cycle, so buf_dout must be written now.
    logic        cp_pend_q, cp_pend_d;
    logic [9:0]  cp_waddr_q, cp_waddr_d;
    logic        scr_rd;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        din_d      = din_q;
        fill_end_d = fill_end_q;
`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
        src_d      = src_q;
        cp_pend_d  = 1'b0;
        cp_waddr_d = cp_waddr_q;
        scr_rd     = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OpWrite: begin
                            we_d    = 1'b1;
                            waddr_d = cmd_addr;
                            din_d   = cmd_data;
                        end
                        OpClrScreen: begin
                            state_d    = StFill;
                            we_d       = 1'b1;
                            waddr_d    = 10'd0;
                            din_d      = FILL_CHAR;
                            fill_end_d = 10'h3FF;
                        end
                        OpClrEol: begin
                            state_d    = StFill;
                            we_d       = 1'b1;
                            waddr_d    = cmd_addr;
                            din_d      = FILL_CHAR;
                            fill_end_d = {cmd_addr[9:6], 6'h3F};
                        end
                        OpClrEos: begin
                            state_d    = StFill;
                            we_d       = 1'b1;
                            waddr_d    = cmd_addr;
                            din_d      = FILL_CHAR;
                            fill_end_d = 10'h3FF;
                        end
`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
                        OpScrollUp: begin
                            state_d = StScrCopy;
                            src_d   = 11'd64;
                        end
`endif
                        default: ;
                    endcase
                end
            end

            StFill: begin
                if (waddr_q == fill_end_q) begin
                    state_d = StIdle;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + 10'd1;
                end
            end

`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
            StScrCopy: begin
                // Video reads take the port; the source pointer simply holds.
                if (!src_q[10] && !vid_rd_en) begin
                    scr_rd     = 1'b1;
                    cp_pend_d  = 1'b1;
                    cp_waddr_d = src_q[9:0] - 10'd64;
                    src_d      = src_q + 11'd1;
                end
                // Last copy (row 14, col 63) is being written this cycle.
                if (cp_pend_q && (cp_waddr_q == 10'd959)) begin
                    state_d    = StScrFill;
                    we_d       = 1'b1;
                    waddr_d    = 10'd960;
                    din_d      = FILL_CHAR;
                    fill_end_d = 10'h3FF;
                end
            end

            StScrFill: begin
                if (waddr_q == fill_end_q) begin
                    state_d = StIdle;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + 10'd1;
                end
            end
`endif

            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers; reset aborts in-flight work, buffer is left as-is.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            waddr_q    <= 10'd0;
            din_q      <= 8'd0;
            fill_end_q <= 10'd0;
`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
            src_q      <= 11'd0;
            cp_pend_q  <= 1'b0;
            cp_waddr_q <= 10'd0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            din_q      <= din_d;
            fill_end_q <= fill_end_d;
`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
            src_q      <= src_d;
            cp_pend_q  <= cp_pend_d;
            cp_waddr_q <= cp_waddr_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

`ifdef CHAR_BUFFER_CTRL_SCROLL_EN
    assign buf_read_en = vid_rd_en | scr_rd;
    assign buf_raddr   = vid_rd_en ? vid_raddr : src_q[9:0];
    // Copy writes and fill writes never overlap: fills start only after the
    // final copy write has been issued.
    assign buf_we      = we_q | cp_pend_q;
    assign buf_waddr   = cp_pend_q ? cp_waddr_q : waddr_q;
    assign buf_din     = cp_pend_q ? buf_dout : din_q;
`else
    logic unused_buf_dout;

    assign unused_buf_dout = ^buf_dout;
    assign buf_read_en     = vid_rd_en;
    assign buf_raddr       = vid_raddr;
    assign buf_we          = we_q;
    assign buf_waddr       = waddr_q;
    assign buf_din         = din_q;
`endif

endmodule

// File: doc/char_buffer_ctrl.md
CHAR_BUFFER_CTRL -- requirements
Module: char_buffer_ctrl

Interface
REQ-001 SHALL have parameter: FILL_CHAR, 8'h20, byte written by clear and scroll-fill operations.
REQ-002 SHALL have port: clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: cmd_valid  input  1  command request.
REQ-005 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port: cmd_op  input  3  0 WRITE, 1 CLEAR_SCREEN, 2 CLEAR_EOL, 3 CLEAR_EOS, 4 SCROLL_UP, 5-7 no-op.
REQ-007 SHALL have port: cmd_addr  input  10  cell address {row[3:0],col[5:0]}.
REQ-008 SHALL have port: cmd_data  input  8  character for WRITE.
REQ-009 SHALL have port: vid_rd_en  input  1  video read request; highest priority.
REQ-010 SHALL have port: vid_raddr  input  10  video read address.
REQ-011 SHALL have ports: buf_we  output  1; buf_waddr  output  10; buf_din  output  8. These form the buffer write port.
REQ-012 SHALL have ports: buf_read_en  output  1; buf_raddr  output  10; buf_dout  input  8. These form the buffer read port; data is valid 1 cycle after buf_read_en.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, FILL, SCR_COPY, SCR_FILL; cmd_ready = (state==IDLE).
REQ-015 SHALL, on WRITE accepted at cycle t, assert buf_we for exactly cycle t+1 with buf_waddr=cmd_addr and buf_din=cmd_data, stay IDLE, and sustain one WRITE per cycle back-to-back.
REQ-016 SHALL, on CLEAR_SCREEN/CLEAR_EOL/CLEAR_EOS, enter FILL and write FILL_CHAR once per cycle, ascending, from start to end inclusive, starting at t+1: 0..1023; cmd_addr..{cmd_addr[9:6],6'h3F}; cmd_addr..1023 respectively.
REQ-017 SHALL return to IDLE the cycle after the last FILL write; CLEAR_EOL at column 63 SHALL perform exactly 1 write.
REQ-018 SHALL, on SCROLL_UP, enter SCR_COPY and, for src 64..1023 ascending, issue read of src, then write buf_dout to src-64 in the cycle after that read.
REQ-019 SHALL drive buf_raddr=vid_raddr and buf_read_en=1 combinationally whenever vid_rd_en is high; scroll reads SHALL stall in those cycles without skipping or repeating any address.
REQ-020 SHALL, after dst 959 is written, enter SCR_FILL and write FILL_CHAR to 960..1023, then return to IDLE.
REQ-021 SHALL complete SCROLL_UP with no video reads in 960+64+1 cycles from acceptance to IDLE, ±1 cycle for pipeline drain.
REQ-022 SHALL accept op 5-7 in one cycle with no buffer write and no state change.
REQ-023 SHALL never assert buf_we for more than one address per cycle, and SHALL never write outside the range defined by the active operation.
REQ-024 SHALL ignore cmd_valid while busy; commands are neither queued nor dropped silently, because cmd_ready is low.

Reset
REQ-025 SHALL, when rst_n is low at a clock edge, force state to IDLE and buf_we=0, buf_read_en=0 (unless vid_rd_en), busy=0, cmd_ready=1 on the next cycle.
REQ-026 SHALL abort any operation in progress on reset; buffer contents already written SHALL be left as-is, with no completion or rollback.

Configuration
REQ-027 SHALL, with macro CHAR_BUFFER_CTRL_SCROLL_EN defined, implement SCROLL_UP per REQ-018..REQ-021.
REQ-028 SHALL, without CHAR_BUFFER_CTRL_SCROLL_EN, omit SCR_COPY/SCR_FILL logic and treat op 4 as a no-op per REQ-022; buf_read_en then follows vid_rd_en only.

Verification
REQ-029 SHALL cover: WRITE addr 10'h041 data 8'h41 at cycle t -> buf_we=1 at t+1 only, waddr 10'h041, din 8'h41.
REQ-030 SHALL cover: CLEAR_EOL addr 10'h07C -> 4 writes of 8'h20 to 124..127, busy for 4 cycles, then cmd_ready=1.
REQ-031 SHALL cover: CLEAR_SCREEN -> 1024 consecutive writes of 8'h20 at 0..1023; cmd_valid pulses during busy are not accepted.
REQ-032 SHALL cover: SCROLL_UP with buffer holding row index in every cell, vid_rd_en toggling every 3rd cycle -> rows 0..14 hold 1..15, row 15 is all 8'h20, and no video read is displaced.
REQ-033 SHALL cover: rst_n low for 1 cycle midway through CLEAR_SCREEN at address 500 -> next cycle is IDLE, buf_we=0, and cells 500..1023 are unchanged.
REQ-034 SHALL cover: build without CHAR_BUFFER_CTRL_SCROLL_EN, op 4 -> accepted in 1 cycle, zero writes, busy stays 0.
